// File: rtl/int2float_rr_sched.sv
// -----------------------------------------------------------------------------
// int2float_rr_sched
//   Shares one combinational 11-bit int -> 7-bit float converter between NREQ
//   requesters. A round-robin arbiter grants at most one valid requester per
//   cycle. The granted operand drives the converter. The result is pushed,
//   tagged with the requester index, into a 2-entry output FIFO that has
//   valid/ready backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  [NREQ]      requester i presents an operand
//   req_data   [NREQ*11]   operand i at bits [11*i+10 : 11*i]
//   req_ready  [NREQ]      one-hot grant (all zero when nothing is accepted)
//   conv_in    [11]        operand sent to the shared converter
//   conv_out   [7]         converter result, combinational in conv_in
//   res_valid              FIFO head valid
//   res_ready              consumer accepts the head
//   res_data   [7]         head result
//   res_tag    [TAGW]      requester index of the head result
//   busy                   any requester valid, or FIFO not empty
//   conv_cnt   [16]        accepted conversions, wraps at 2^16
// -----------------------------------------------------------------------------
module int2float_rr_sched #(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*11-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [10:0]          conv_in,
    input  logic [6:0]           conv_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [6:0]           res_data,
    output logic [TAGW-1:0]      res_tag,
    output logic                 busy,
    output logic [15:0]          conv_cnt
);

    typedef struct packed {
        logic [6:0]      data;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t          fifo_q [2];
    logic            wr_q;
    logic            rd_q;
    logic [1:0]      count_q;
    logic [TAGW-1:0] ptr_q;
    logic [10:0]     last_q;

    logic            grant_vld;
    logic [TAGW-1:0] grant_idx;
    logic            push;
    logic            pop;

    // Round-robin search starting at ptr_q. Acceptance only considers the
    // occupancy at the start of the cycle; a same-cycle pop does not free a
    // slot. Nothing is granted while reset is held.
    always_comb begin
        int unsigned j;
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        if (!rst && count_q != 2'd2) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(ptr_q) + k) % NREQ;
                if (!grant_vld && req_valid[j]) begin
                    grant_vld = 1'b1;
                    grant_idx = TAGW'(j);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_vld && (grant_idx == TAGW'(i));
        end
    end

    // With no grant the converter keeps seeing the last granted operand.
    assign conv_in   = grant_vld ? req_data[int'(grant_idx)*11 +: 11] : last_q;

    assign push      = grant_vld;
    assign res_valid = (count_q != 2'd0);
    assign pop       = res_valid && res_ready;
    assign res_data  = fifo_q[rd_q].data;
    assign res_tag   = fifo_q[rd_q].tag;
    assign busy      = (|req_valid) || (count_q != 2'd0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            ptr_q     <= '0;
            count_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            conv_cnt  <= '0;
            last_q    <= '0;
            // NOTE: the two storage entries are cleared as well, because the
            // head is visible on res_data/res_tag and must read zero after reset.
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= '{data: conv_out, tag: grant_idx};
                wr_q         <= ~wr_q;
                last_q       <= conv_in;
                conv_cnt     <= conv_cnt + 16'd1;
                ptr_q        <= (grant_idx == TAGW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_int2float_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_int2float_rr_sched
//   Self-checking bench for int2float_rr_sched (NREQ=4, TAGW=2). The converter
//   is a stub: conv_out = conv_in[6:0] ^ 7'h55. Inputs change 1 time unit
//   after the rising edge and outputs are sampled 2 units later.
// -----------------------------------------------------------------------------
module tb_int2float_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [43:0] req_data;
    logic [3:0]  req_ready;
    logic [10:0] conv_in;
    logic [6:0]  conv_out;
    logic        res_valid;
    logic        res_ready;
    logic [6:0]  res_data;
    logic [1:0]  res_tag;
    logic        busy;
    logic [15:0] conv_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign conv_out = conv_in[6:0] ^ 7'h55;

    int2float_rr_sched #(.NREQ(4), .TAGW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .conv_in   (conv_in),
        .conv_out  (conv_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .busy      (busy),
        .conv_cnt  (conv_cnt)
    );

    // Fixed operands for the directed tests and their hand-computed results.
    localparam logic [43:0] FIXED_DATA = {11'h70F, 11'h2F0, 11'h1C5, 11'h03A};

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        rr;
        logic [3:0]  ready;
        logic [10:0] cin;
        logic        vld;
        logic [1:0]  tag;
        logic [6:0]  data;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [6:0] data;
        logic [1:0] tag;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t vec [13];
    res_t mq [$];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = FIXED_DATA;
        res_ready = 1'b0;
        do_reset();

        // Reset state.
        settle();
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_data",  32'(res_data),  32'd0);
        check("reset res_tag",   32'(res_tag),   32'd0);
        check("reset conv_in",   32'(conv_in),   32'd0);
        check("reset conv_cnt",  32'(conv_cnt),  32'd0);
        check("reset busy",      32'(busy),      32'd0);

        // Single requester, then a reset row, then all four valid for 8 cycles.
        //            rst   rv     rr    ready   cin      vld  tag   data    cnt
        vec[0]  = '{1'b0, 4'h1, 1'b1, 4'h1, 11'h03A, 1'b0, 2'd0, 7'h00, 16'd0};
        vec[1]  = '{1'b0, 4'h0, 1'b1, 4'h0, 11'h03A, 1'b1, 2'd0, 7'h6F, 16'd1};
        vec[2]  = '{1'b1, 4'hF, 1'b1, 4'h0, 11'h03A, 1'b0, 2'd0, 7'h00, 16'd1};
        vec[3]  = '{1'b0, 4'hF, 1'b1, 4'h1, 11'h03A, 1'b0, 2'd0, 7'h00, 16'd0};
        vec[4]  = '{1'b0, 4'hF, 1'b1, 4'h2, 11'h1C5, 1'b1, 2'd0, 7'h6F, 16'd1};
        vec[5]  = '{1'b0, 4'hF, 1'b1, 4'h4, 11'h2F0, 1'b1, 2'd1, 7'h10, 16'd2};
        vec[6]  = '{1'b0, 4'hF, 1'b1, 4'h8, 11'h70F, 1'b1, 2'd2, 7'h25, 16'd3};
        vec[7]  = '{1'b0, 4'hF, 1'b1, 4'h1, 11'h03A, 1'b1, 2'd3, 7'h5A, 16'd4};
        vec[8]  = '{1'b0, 4'hF, 1'b1, 4'h2, 11'h1C5, 1'b1, 2'd0, 7'h6F, 16'd5};
        vec[9]  = '{1'b0, 4'hF, 1'b1, 4'h4, 11'h2F0, 1'b1, 2'd1, 7'h10, 16'd6};
        vec[10] = '{1'b0, 4'hF, 1'b1, 4'h8, 11'h70F, 1'b1, 2'd2, 7'h25, 16'd7};
        vec[11] = '{1'b0, 4'h0, 1'b1, 4'h0, 11'h70F, 1'b1, 2'd3, 7'h5A, 16'd8};
        vec[12] = '{1'b0, 4'h0, 1'b1, 4'h0, 11'h70F, 1'b0, 2'd0, 7'h00, 16'd8};

        for (int i = 0; i < 13; i++) begin
            rst       = vec[i].rst;
            req_valid = vec[i].rv;
            res_ready = vec[i].rr;
            settle();
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vec[i].ready));
            check($sformatf("vec%0d conv_in", i),   32'(conv_in),   32'(vec[i].cin));
            check($sformatf("vec%0d res_valid", i), 32'(res_valid), 32'(vec[i].vld));
            check($sformatf("vec%0d conv_cnt", i),  32'(conv_cnt),  32'(vec[i].cnt));
            if (vec[i].vld) begin
                check($sformatf("vec%0d res_tag", i),  32'(res_tag),  32'(vec[i].tag));
                check($sformatf("vec%0d res_data", i), 32'(res_data), 32'(vec[i].data));
            end
            tick();
        end
        rst = 1'b0;
        settle();
        check("idle busy", 32'(busy), 32'd0);

        // Backpressure: two grants fill the FIFO, head held stable, then a
        // full cycle with a pop grants nothing and the next cycle resumes at 2.
        do_reset();
        req_valid = 4'hF;
        res_ready = 1'b0;
        settle();
        check("bp grant0", 32'(req_ready), 32'h1);
        tick();
        settle();
        check("bp grant1", 32'(req_ready), 32'h2);
        check("bp head tag0", 32'(res_tag), 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp full no grant", 32'(req_ready), 32'h0);
            check("bp hold tag",      32'(res_tag),   32'd0);
            check("bp hold data",     32'(res_data),  32'h6F);
            check("bp busy",          32'(busy),      32'd1);
            tick();
        end
        res_ready = 1'b1;
        settle();
        check("full+pop no grant", 32'(req_ready), 32'h0);
        check("full+pop head tag", 32'(res_tag),   32'd0);
        tick();
        settle();
        check("resume grant2",  32'(req_ready), 32'h4);
        check("resume head1",   32'(res_tag),   32'd1);
        check("resume data1",   32'(res_data),  32'h10);
        tick();
        settle();
        check("resume grant3",  32'(req_ready), 32'h8);
        check("resume head2",   32'(res_tag),   32'd2);
        check("resume cnt",     32'(conv_cnt),  32'd3);

        // Reset mid-stream with count=2 and ptr=3.
        do_reset();
        req_valid = 4'h2;
        settle();
        check("mid grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'h4;
        settle();
        check("mid grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'hF;
        settle();
        check("mid full", 32'(req_ready), 32'h0);
        rst = 1'b1;
        tick();
        settle();
        check("mid rst res_valid", 32'(res_valid), 32'd0);
        check("mid rst conv_cnt",  32'(conv_cnt),  32'd0);
        check("mid rst req_ready", 32'(req_ready), 32'h0);
        check("mid rst conv_in",   32'(conv_in),   32'd0);
        rst = 1'b0;
        settle();
        check("post rst grant0", 32'(req_ready), 32'h1);

        // Random traffic against a behavioural arbiter + FIFO model.
        begin
            int          mptr;
            int          mcnt;
            int          pops;
            logic [3:0]  exp_ready;
            int          gidx;
            do_reset();
            mq.delete();
            mptr = 0;
            mcnt = 0;
            pops = 0;
            for (int c = 0; c < 220; c++) begin
                req_valid = 4'($urandom_range(0, 15));
                res_ready = ($urandom_range(0, 3) != 0);
                req_data  = {11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom)};
                settle();
                exp_ready = '0;
                gidx      = -1;
                if (mq.size() < 2) begin
                    for (int k = 0; k < 4; k++) begin
                        int j;
                        j = (mptr + k) % 4;
                        if (gidx < 0 && req_valid[j]) gidx = j;
                    end
                end
                if (gidx >= 0) exp_ready[gidx] = 1'b1;
                check("rnd req_ready", 32'(req_ready), 32'(exp_ready));
                check("rnd res_valid", 32'(res_valid), 32'(mq.size() != 0));
                if (mq.size() != 0) begin
                    check("rnd res_tag",  32'(res_tag),  32'(mq[0].tag));
                    check("rnd res_data", 32'(res_data), 32'(mq[0].data));
                end
                if (res_ready && mq.size() != 0) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (gidx >= 0) begin
                    logic [10:0] op;
                    op = req_data[gidx*11 +: 11];
                    mq.push_back('{data: op[6:0] ^ 7'h55, tag: 2'(gidx)});
                    mptr = (gidx + 1) % 4;
                    mcnt++;
                end
                tick();
            end
            req_valid = '0;
            res_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                settle();
                if (mq.size() != 0) begin
                    check("drain tag", 32'(res_tag), 32'(mq[0].tag));
                    void'(mq.pop_front());
                    pops++;
                end
                tick();
            end
            settle();
            check("rnd conv_cnt", 32'(conv_cnt), 32'(16'(mcnt)));
            check("rnd empty",    32'(res_valid), 32'd0);
            check("rnd enough ops", 32'(pops >= 100), 32'd1);
        end

        // Counter wrap.
        do_reset();
        req_data  = FIXED_DATA;
        req_valid = 4'h1;
        res_ready = 1'b1;
        repeat (65535) tick();
        settle();
        check("wrap ffff", 32'(conv_cnt), 32'hFFFF);
        tick();
        settle();
        check("wrap zero", 32'(conv_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
